// File: rtl/ps_pl_platform_wrapper.sv
// ---------------------------------------------------------------------------
// ps_pl_platform_wrapper
// Programmable-logic shell of the NTT accelerator platform. It contains:
//   - the AXI4-Lite control slave with the CTRL and STATUS registers,
//   - the IDLE/RUN sequencer that launches the external NTT core,
//   - the 256x32 single-port coefficient buffer, which the DMA port owns
//     in IDLE and the core owns in RUN,
//   - a level interrupt that mirrors STATUS.DONE.
//
// Ports:
//   ACLK, ARESET          clock, synchronous active-high reset
//   s_aw*/s_w*/s_b*       AXI4-Lite write channels (4-bit byte address)
//   s_ar*/s_r*            AXI4-Lite read channels
//   dma_*                 DMA word port into the buffer (1-cycle read latency)
//   core_start/core_mode  launch pulse and transform direction to the core
//   core_done             completion pulse from the core
//   core_en/we/addr/...   core word port into the buffer (1-cycle latency)
//   irq                   level interrupt, equal to STATUS.DONE
// ---------------------------------------------------------------------------
module ps_pl_platform_wrapper #(
  parameter int unsigned N_WORDS = 256,
  parameter int unsigned ADDR_W  = 8
) (
  input  logic              ACLK,
  input  logic              ARESET,
  // AXI4-Lite write address / data / response
  input  logic [3:0]        s_awaddr,
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [31:0]       s_wdata,
  input  logic              s_wvalid,
  output logic              s_wready,
  output logic [1:0]        s_bresp,
  output logic              s_bvalid,
  input  logic              s_bready,
  // AXI4-Lite read address / data
  input  logic [3:0]        s_araddr,
  input  logic              s_arvalid,
  output logic              s_arready,
  output logic [31:0]       s_rdata,
  output logic [1:0]        s_rresp,
  output logic              s_rvalid,
  input  logic              s_rready,
  // DMA buffer port
  input  logic              dma_en,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [31:0]       dma_wdata,
  output logic [31:0]       dma_rdata,
  // NTT core control
  output logic              core_start,
  output logic              core_mode,
  input  logic              core_done,
  // NTT core buffer port
  input  logic              core_en,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [31:0]       core_wdata,
  output logic [31:0]       core_rdata,
  output logic              irq
);

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned CTRL_W   = 2;
  localparam logic [1:0]  REG_CTRL = 2'd0;
  localparam logic [1:0]  REG_STAT = 2'd1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t              state;
  logic [CTRL_W-1:0]   ctrl_q;
  logic                err_q;
  logic                start_pend;

  logic [DATA_W-1:0]   mem [N_WORDS];

  // Channel handshakes; awready/wready and arready are registered one-cycle pulses.
  logic wr_hs;
  logic rd_hs;
  logic wr_ctrl;
  logic wr_stat;
  logic start_req;
  logic run;

  assign wr_hs     = s_awready & s_awvalid & s_wready & s_wvalid;
  assign rd_hs     = s_arready & s_arvalid;
  assign wr_ctrl   = wr_hs & (s_awaddr[3:2] == REG_CTRL);
  assign wr_stat   = wr_hs & (s_awaddr[3:2] == REG_STAT);
  assign start_req = wr_ctrl & s_wdata[0];
  assign run       = (state == ST_RUN);

  assign s_bresp = 2'b00;
  assign s_rresp = 2'b00;

  // Sticky status flags: set has priority over a simultaneous write-1-to-clear.
  logic done_set;
  logic err_set;
  logic done_nxt;
  logic err_nxt;

  always_comb begin
    done_set = run & core_done;
    err_set  = (run & start_req) | (run & dma_en);
    done_nxt = done_set | (irq   & ~(wr_stat & s_wdata[0]));
    err_nxt  = err_set  | (err_q & ~(wr_stat & s_wdata[2]));
  end

  // Register read mux, sampled in the arready cycle (pre-write values).
  logic [DATA_W-1:0] rd_val;

  always_comb begin
    rd_val = '0;
    case (s_araddr[3:2])
      REG_CTRL: rd_val = {(DATA_W-CTRL_W)'(0), ctrl_q};
      REG_STAT: rd_val = {(DATA_W-3)'(0), err_q, run, irq};
      default:  rd_val = '0;
    endcase
  end

  // Single buffer port: the sequencer state selects the owner.
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              dma_rd;
  logic              core_rd;

  always_comb begin
    mem_en    = run ? core_en    : dma_en;
    mem_we    = run ? core_we    : dma_we;
    mem_addr  = run ? core_addr  : dma_addr;
    mem_wdata = run ? core_wdata : dma_wdata;
    dma_rd    = ~run & dma_en  & ~dma_we;
    core_rd   =  run & core_en & ~core_we;
  end

  // Buffer contents are not reset.
  always_ff @(posedge ACLK) begin
    if (mem_en && mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  // Read data of the non-owning port (and of non-read cycles) is forced to 0.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      dma_rdata  <= '0;
      core_rdata <= '0;
    end else begin
      dma_rdata  <= dma_rd  ? mem[mem_addr] : '0;
      core_rdata <= core_rd ? mem[mem_addr] : '0;
    end
  end

  // AXI4-Lite write channel: one outstanding write, ready only while no response pending.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      s_awready <= 1'b0;
      s_wready  <= 1'b0;
      s_bvalid  <= 1'b0;
    end else begin
      s_awready <= ~s_awready & s_awvalid & s_wvalid & ~s_bvalid;
      s_wready  <= ~s_awready & s_awvalid & s_wvalid & ~s_bvalid;
      if (wr_hs) begin
        s_bvalid <= 1'b1;
      end else if (s_bready) begin
        s_bvalid <= 1'b0;
      end
    end
  end

  // AXI4-Lite read channel: data captured at the address handshake, held until rready.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      s_arready <= 1'b0;
      s_rvalid  <= 1'b0;
      s_rdata   <= '0;
    end else begin
      s_arready <= ~s_arready & s_arvalid & ~s_rvalid;
      if (rd_hs) begin
        s_rvalid <= 1'b1;
        s_rdata  <= rd_val;
      end else if (s_rready) begin
        s_rvalid <= 1'b0;
      end
    end
  end

  // Register file and run sequencer.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state      <= ST_IDLE;
      ctrl_q     <= '0;
      err_q      <= 1'b0;
      irq        <= 1'b0;
      core_mode  <= 1'b0;
      core_start <= 1'b0;
      start_pend <= 1'b0;
    end else begin
      start_pend <= 1'b0;
      // The launch pulse trails the accepting edge by one extra cycle.
      core_start <= start_pend;
      irq        <= done_nxt;
      err_q      <= err_nxt;
      if (wr_ctrl) begin
        ctrl_q <= s_wdata[CTRL_W-1:0];
      end
      case (state)
        ST_IDLE: begin
          if (start_req) begin
            state      <= ST_RUN;
            core_mode  <= s_wdata[1];
            start_pend <= 1'b1;
          end
        end
        ST_RUN: begin
          if (core_done) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Address LSBs and upper write-data bits carry no information.
  logic unused_ok;
  assign unused_ok = ^{s_awaddr[1:0], s_araddr[1:0], s_wdata[31:3]};

endmodule

// File: tb/tb_ps_pl_platform_wrapper.sv
// ---------------------------------------------------------------------------
// tb_ps_pl_platform_wrapper
// Directed bench for ps_pl_platform_wrapper: reset state, DMA load/readback,
// forward and inverse runs, core buffer access, error flags, simultaneous
// AXI read/write ordering and reset in the middle of a run.
// ---------------------------------------------------------------------------
module tb_ps_pl_platform_wrapper;

  localparam int unsigned N_WORDS = 256;
  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned TMO     = 20;

  logic              tb_ACLK;
  logic              ARESET;
  logic [3:0]        s_awaddr;
  logic              s_awvalid;
  logic              s_awready;
  logic [31:0]       s_wdata;
  logic              s_wvalid;
  logic              s_wready;
  logic [1:0]        s_bresp;
  logic              s_bvalid;
  logic              s_bready;
  logic [3:0]        s_araddr;
  logic              s_arvalid;
  logic              s_arready;
  logic [31:0]       s_rdata;
  logic [1:0]        s_rresp;
  logic              s_rvalid;
  logic              s_rready;
  logic              dma_en;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [31:0]       dma_wdata;
  logic [31:0]       dma_rdata;
  logic              core_start;
  logic              core_mode;
  logic              core_done;
  logic              core_en;
  logic              core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [31:0]       core_wdata;
  logic [31:0]       core_rdata;
  logic              irq;

  int checks   = 0;
  int failures = 0;
  int start_cnt  = 0;
  logic start_mode = 1'b0;

  ps_pl_platform_wrapper #(.N_WORDS(N_WORDS), .ADDR_W(ADDR_W)) dut (
    .ACLK       (tb_ACLK),
    .ARESET     (ARESET),
    .s_awaddr   (s_awaddr),
    .s_awvalid  (s_awvalid),
    .s_awready  (s_awready),
    .s_wdata    (s_wdata),
    .s_wvalid   (s_wvalid),
    .s_wready   (s_wready),
    .s_bresp    (s_bresp),
    .s_bvalid   (s_bvalid),
    .s_bready   (s_bready),
    .s_araddr   (s_araddr),
    .s_arvalid  (s_arvalid),
    .s_arready  (s_arready),
    .s_rdata    (s_rdata),
    .s_rresp    (s_rresp),
    .s_rvalid   (s_rvalid),
    .s_rready   (s_rready),
    .dma_en     (dma_en),
    .dma_we     (dma_we),
    .dma_addr   (dma_addr),
    .dma_wdata  (dma_wdata),
    .dma_rdata  (dma_rdata),
    .core_start (core_start),
    .core_mode  (core_mode),
    .core_done  (core_done),
    .core_en    (core_en),
    .core_we    (core_we),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_rdata (core_rdata),
    .irq        (irq)
  );

  initial tb_ACLK = 1'b0;
  always #5 tb_ACLK = ~tb_ACLK;

  // Launch pulse monitor: counts pulses and records the mode seen with each.
  always @(posedge tb_ACLK) begin
    if (core_start === 1'b1) begin
      start_cnt  = start_cnt + 1;
      start_mode = core_mode;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    if (obs !== exp) begin
      failures = failures + 1;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge tb_ACLK);
      #1;
    end
  endtask

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data);
    logic ok;
    s_awaddr  = addr;
    s_wdata   = data;
    s_awvalid = 1'b1;
    s_wvalid  = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < TMO && !ok; n++) begin
      tick(1);
      if (s_awready && s_wready) begin
        tick(1);
        ok = 1'b1;
      end
    end
    s_awvalid = 1'b0;
    s_wvalid  = 1'b0;
    check("aw_w_handshake", 32'(ok), 32'd1);
    ok = 1'b0;
    for (int n = 0; n < TMO && !ok; n++) begin
      if (s_bvalid) ok = 1'b1;
      else tick(1);
    end
    check("bvalid", 32'(ok), 32'd1);
    check("bresp", 32'(s_bresp), 32'd0);
    s_bready = 1'b1;
    tick(1);
    s_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
    logic ok;
    s_araddr  = addr;
    s_arvalid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < TMO && !ok; n++) begin
      tick(1);
      if (s_arready) begin
        tick(1);
        ok = 1'b1;
      end
    end
    s_arvalid = 1'b0;
    check("ar_handshake", 32'(ok), 32'd1);
    ok = 1'b0;
    for (int n = 0; n < TMO && !ok; n++) begin
      if (s_rvalid) ok = 1'b1;
      else tick(1);
    end
    check("rvalid", 32'(ok), 32'd1);
    data = s_rdata;
    s_rready = 1'b1;
    tick(1);
    s_rready = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [3:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    axi_read(addr, d);
    check(tag, d, exp);
  endtask

  task automatic pulse_done();
    core_done = 1'b1;
    tick(1);
    core_done = 1'b0;
  endtask

  task automatic dma_read_check(input string tag, input logic [ADDR_W-1:0] a, input logic [31:0] exp);
    dma_en   = 1'b1;
    dma_we   = 1'b0;
    dma_addr = a;
    tick(1);
    dma_en   = 1'b0;
    check(tag, dma_rdata, exp);
  endtask

  initial begin
    logic ok;
    ARESET = 1'b1;
    s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wvalid = 1'b0; s_bready = 1'b0;
    s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;
    dma_en = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    core_done = 1'b0; core_en = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;

    // Reset state
    tick(20);
    check("rst_irq",        32'(irq),        32'd0);
    check("rst_core_start", 32'(core_start), 32'd0);
    check("rst_core_mode",  32'(core_mode),  32'd0);
    check("rst_ready_valid",
          32'({s_awready, s_wready, s_bvalid, s_arready, s_rvalid}), 32'd0);
    check("rst_rdata", dma_rdata | core_rdata | s_rdata, 32'd0);
    ARESET = 1'b0;
    tick(1);
    read_check("rst_ctrl",   4'h0, 32'h0);
    read_check("rst_status", 4'h4, 32'h0);
    read_check("unmapped_8", 4'h8, 32'h0);

    // DMA load and readback in IDLE
    for (int i = 0; i < int'(N_WORDS); i++) begin
      dma_en = 1'b1; dma_we = 1'b1; dma_addr = ADDR_W'(i); dma_wdata = 32'h1000 + 32'(i);
      tick(1);
    end
    for (int i = 0; i < int'(N_WORDS); i++) begin
      dma_en = 1'b1; dma_we = 1'b0; dma_addr = ADDR_W'(i);
      tick(1);
      check("dma_readback", dma_rdata, 32'h1000 + 32'(i));
    end
    dma_en = 1'b0;
    tick(1);

    // Core port ignored in IDLE: write dropped and core_rdata stays 0
    core_en = 1'b1; core_we = 1'b1; core_addr = 8'd6; core_wdata = 32'hDEAD;
    tick(1);
    core_we = 1'b0;
    tick(1);
    core_en = 1'b0;
    check("core_rdata_idle", core_rdata, 32'h0);
    dma_read_check("core_wr_idle_dropped", 8'd6, 32'h1006);

    // core_done in IDLE is ignored
    pulse_done();
    read_check("done_in_idle", 4'h4, 32'h0);

    // Forward run
    start_cnt = 0;
    axi_write(4'h0, 32'h1);
    axi_write(4'h0, 32'h0);
    tick(3);
    check("fwd_start_cnt",  32'(start_cnt),  32'd1);
    check("fwd_start_mode", 32'(start_mode), 32'd0);
    read_check("fwd_status_busy", 4'h4, 32'h2);
    read_check("fwd_ctrl_rb",     4'h0, 32'h0);
    check("fwd_irq_busy", 32'(irq), 32'd0);
    pulse_done();
    check("fwd_irq_done", 32'(irq), 32'd1);
    read_check("fwd_status_done", 4'h4, 32'h1);
    axi_write(4'h4, 32'h1);
    read_check("fwd_status_clr", 4'h4, 32'h0);
    check("fwd_irq_clr", 32'(irq), 32'd0);

    // Inverse run with core buffer access
    start_cnt = 0;
    axi_write(4'h0, 32'h3);
    tick(3);
    check("inv_start_cnt",  32'(start_cnt),  32'd1);
    check("inv_start_mode", 32'(start_mode), 32'd1);
    core_en = 1'b1; core_we = 1'b1; core_addr = 8'd5; core_wdata = 32'hABCD;
    tick(1);
    core_we = 1'b0;
    tick(1);
    core_en = 1'b0;
    check("inv_core_rdata", core_rdata, 32'hABCD);
    check("inv_mode_mid",   32'(core_mode), 32'd1);
    pulse_done();
    check("inv_mode_end", 32'(core_mode), 32'd1);
    dma_read_check("inv_dma_addr5", 8'd5, 32'hABCD);
    dma_read_check("inv_dma_addr4", 8'd4, 32'h1004);
    axi_write(4'h4, 32'h1);
    read_check("inv_status_clr", 4'h4, 32'h0);

    // Errors during a run
    start_cnt = 0;
    axi_write(4'h0, 32'h1);
    tick(3);
    axi_write(4'h0, 32'h1);
    dma_en = 1'b1; dma_we = 1'b1; dma_addr = 8'd0; dma_wdata = 32'hFFFF;
    tick(1);
    dma_read_check("err_dma_rd_run", 8'd0, 32'h0);
    tick(3);
    check("err_start_cnt", 32'(start_cnt), 32'd1);
    check("err_mode_kept", 32'(core_mode), 32'd0);
    read_check("err_status_run", 4'h4, 32'h6);
    pulse_done();
    read_check("err_status_done", 4'h4, 32'h5);
    dma_read_check("err_addr0_kept", 8'd0, 32'h1000);
    axi_write(4'h4, 32'h4);
    read_check("err_clr", 4'h4, 32'h1);
    axi_write(4'h4, 32'h1);
    read_check("err_all_clr", 4'h4, 32'h0);

    // Simultaneous read and write of CTRL: read returns the pre-write value
    axi_write(4'h0, 32'h2);
    s_awaddr = 4'h0; s_wdata = 32'h0; s_araddr = 4'h0;
    s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < int'(TMO) && !ok; n++) begin
      tick(1);
      if (s_arready && s_awready) begin
        tick(1);
        ok = 1'b1;
      end
    end
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
    check("simul_handshake", 32'(ok), 32'd1);
    check("simul_rvalid_bvalid", 32'({s_rvalid, s_bvalid}), 32'd3);
    check("simul_pre_write", s_rdata, 32'h2);
    s_rready = 1'b1; s_bready = 1'b1;
    tick(1);
    s_rready = 1'b0; s_bready = 1'b0;
    read_check("simul_post_write", 4'h0, 32'h0);
    read_check("simul_no_start", 4'h4, 32'h0);

    // Reset in the middle of a run, then a late core_done
    axi_write(4'h0, 32'h3);
    tick(3);
    read_check("mid_busy", 4'h4, 32'h2);
    ARESET = 1'b1;
    tick(1);
    ARESET = 1'b0;
    tick(1);
    pulse_done();
    tick(1);
    check("mid_irq", 32'(irq), 32'd0);
    check("mid_mode", 32'(core_mode), 32'd0);
    read_check("mid_status", 4'h4, 32'h0);
    read_check("mid_ctrl",   4'h0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
